// File: rtl/mips_pipeline_mem_wb_writeback_pkg.sv
// Shared constants for the MEM/WB write-back slice: default widths, load-size
// encodings and the hard-wired zero register index.
package mips_pipeline_mem_wb_writeback_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/mips_load_extract.sv
// Little-endian sub-word load extraction with sign/zero extension.
// Purely combinational; any size encoding other than byte/half returns the word.
module mips_load_extract
    import mips_pipeline_mem_wb_writeback_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] mem_out,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [WORD_W-1:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (off)
            2'd0:    byte_sel = mem_out[7:0];
            2'd1:    byte_sel = mem_out[15:8];
            2'd2:    byte_sel = mem_out[23:16];
            default: byte_sel = mem_out[31:24];
        endcase
        // off[0] is not looked at: misaligned halfwords never reach this stage
        half_sel = off[1] ? mem_out[31:16] : mem_out[15:0];
    end

    always_comb begin
        extracted = mem_out;
        case (size)
            MEM_SIZE_BYTE: extracted = {{(WORD_W-8){sign_ext & byte_sel[7]}}, byte_sel};
            MEM_SIZE_HALF: extracted = {{(WORD_W-16){sign_ext & half_sel[15]}}, half_sel};
            default:       extracted = mem_out;
        endcase
    end

endmodule

// File: rtl/mips_pipeline_mem_wb_writeback.sv
// MEM/WB pipeline register plus WB stage: load extraction, write-back select,
// register-file write port, WB->EX forwarding and a retired-instruction counter.
module mips_pipeline_mem_wb_writeback #(
    parameter int WORD_W     = mips_pipeline_mem_wb_writeback_pkg::WORD_W,
    parameter int REG_ADDR_W = mips_pipeline_mem_wb_writeback_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [1:0]            in_mem_size,
    input  logic                  in_mem_signed,
    input  logic [WORD_W-1:0]     in_alu_out,
    input  logic [WORD_W-1:0]     in_mem_out,
    input  logic [REG_ADDR_W-1:0] in_dest_reg,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WORD_W-1:0]     rf_wdata,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [WORD_W-1:0]     fwd_data,
    output logic [CNT_W-1:0]      retired
);

    import mips_pipeline_mem_wb_writeback_pkg::*;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [1:0]            mem_size;
        logic                  mem_signed;
        logic [WORD_W-1:0]     alu_out;
        logic [WORD_W-1:0]     mem_out;
        logic [REG_ADDR_W-1:0] dest_reg;
    } mem_wb_t;

    mem_wb_t            mem_wb_q;
    mem_wb_t            mem_wb_d;
    logic [WORD_W-1:0]  load_dat;
    logic [WORD_W-1:0]  wb_dat;
    logic               we;

    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.valid      = in_valid;
        mem_wb_d.reg_write  = in_reg_write;
        mem_wb_d.mem_to_reg = in_mem_to_reg;
        mem_wb_d.mem_size   = in_mem_size;
        mem_wb_d.mem_signed = in_mem_signed;
        mem_wb_d.alu_out    = in_alu_out;
        mem_wb_d.mem_out    = in_mem_out;
        mem_wb_d.dest_reg   = in_dest_reg;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_wb_q <= '0;
        end else if (flush) begin
            mem_wb_q <= '0;
        end else if (!stall) begin
            mem_wb_q <= mem_wb_d;
        end
    end

    // The instruction in WB retires when it leaves, which a same-cycle flush does not undo.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (mem_wb_q.valid && !stall) begin
            retired <= retired + CNT_W'(1);
        end
    end

    mips_load_extract #(
        .WORD_W (WORD_W)
    ) u_load_extract (
        .mem_out   (mem_wb_q.mem_out),
        .off       (mem_wb_q.alu_out[1:0]),
        .size      (mem_wb_q.mem_size),
        .sign_ext  (mem_wb_q.mem_signed),
        .extracted (load_dat)
    );

    always_comb begin
        wb_dat = mem_wb_q.mem_to_reg ? load_dat : mem_wb_q.alu_out;
        we     = mem_wb_q.valid && mem_wb_q.reg_write
                 && (mem_wb_q.dest_reg != REG_ADDR_W'(ZERO_REG));
    end

    assign rf_we     = we;
    assign rf_waddr  = mem_wb_q.dest_reg;
    assign rf_wdata  = wb_dat;
    assign fwd_valid = we;
    assign fwd_reg   = mem_wb_q.dest_reg;
    assign fwd_data  = wb_dat;

endmodule
